// File: rtl/branch_resolve_unit_pkg.sv
// Shared decode constants and FSM encoding for the ID-stage branch resolution unit.
package branch_resolve_unit_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [4:0] RT_BLTZ    = 5'b00000;
  localparam logic [4:0] RT_BGEZ    = 5'b00001;

  localparam logic [4:0] LINK_RA    = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_FLUSH
  } brs_state_e;

endpackage

// File: rtl/branch_resolve_unit_decide.sv
// Combinational decode of MIPS control-transfer instructions: taken/target/link info.
module branch_decide
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter bit          ENABLE_JALR = 1'b1
) (
  input  logic             valid_i,
  input  logic [31:0]      instr_i,
  input  logic [XLEN-29:0] pc_hi_i,
  input  logic [XLEN-1:0]  pc_plus_branch_i,
  input  logic [XLEN-1:0]  rs_i,
  input  logic [XLEN-1:0]  rt_i,
  output logic             take_o,
  output logic [XLEN-1:0]  target_o,
  output logic             is_cond_o,
  output logic             is_link_o,
  output logic [4:0]       link_reg_o
);

  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [4:0]      rt_field;
  logic            rs_neg;
  logic            rs_zero;
  logic            rs_eq_rt;
  logic [XLEN-1:0] jump_tgt;

  assign opcode   = instr_i[31:26];
  assign funct    = instr_i[5:0];
  assign rt_field = instr_i[20:16];
  // Signed compares against zero reduce to sign bit and zero test.
  assign rs_neg   = rs_i[XLEN-1];
  assign rs_zero  = (rs_i == '0);
  assign rs_eq_rt = (rs_i == rt_i);
  assign jump_tgt = {pc_hi_i, instr_i[25:0], 2'b00};

  always_comb begin
    take_o     = 1'b0;
    target_o   = pc_plus_branch_i;
    is_cond_o  = 1'b0;
    is_link_o  = 1'b0;
    link_reg_o = LINK_RA;
    if (valid_i) begin
      case (opcode)
        OP_SPECIAL: begin
          if (funct == FN_JR) begin
            take_o   = 1'b1;
            target_o = rs_i;
          end else if (ENABLE_JALR && (funct == FN_JALR)) begin
            take_o     = 1'b1;
            target_o   = rs_i;
            is_link_o  = 1'b1;
            link_reg_o = instr_i[15:11];
          end
        end
        OP_J: begin
          take_o   = 1'b1;
          target_o = jump_tgt;
        end
        OP_JAL: begin
          take_o    = 1'b1;
          target_o  = jump_tgt;
          is_link_o = 1'b1;
        end
        OP_BEQ: begin
          is_cond_o = 1'b1;
          take_o    = rs_eq_rt;
        end
        OP_BNE: begin
          is_cond_o = 1'b1;
          take_o    = !rs_eq_rt;
        end
        OP_BLEZ: begin
          is_cond_o = 1'b1;
          take_o    = rs_neg || rs_zero;
        end
        OP_BGTZ: begin
          is_cond_o = 1'b1;
          take_o    = !rs_neg && !rs_zero;
        end
        OP_REGIMM: begin
          if (rt_field == RT_BLTZ) begin
            is_cond_o = 1'b1;
            take_o    = rs_neg;
          end else if (rt_field == RT_BGEZ) begin
            is_cond_o = 1'b1;
            take_o    = !rs_neg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch/jump resolution: redirect strobe, IF flush window, link write, statistics.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16,
  parameter bit          ENABLE_JALR  = 1'b1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Valid_ID,
  input  logic [31:0]      Instruction,
  input  logic [XLEN-1:0]  PC_Plus_4,
  input  logic [XLEN-1:0]  PC_Plus_Branch,
  input  logic [XLEN-1:0]  Reg_Data1,
  input  logic [XLEN-1:0]  Reg_Data2,
  input  logic             Stall_PC,
  output logic             PCSel,
  output logic [XLEN-1:0]  BranchPC,
  output logic             Flush_IF,
  output logic             Link_Write,
  output logic [4:0]       Link_Reg,
  output logic [XLEN-1:0]  Link_Addr,
  output logic [CNT_W-1:0] Branch_Count,
  output logic [CNT_W-1:0] Taken_Count
);

  localparam int unsigned    FW         = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0]  FLUSH_INIT = FW'(FLUSH_CYCLES);

  logic             dec_take;
  logic [XLEN-1:0]  dec_target;
  logic             dec_cond;
  logic             dec_link;
  logic [4:0]       dec_link_reg;
  logic [XLEN-1:0]  dec_link_addr;

  brs_state_e       state_q, state_d;
  logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
  logic             pcsel_q, pcsel_d;
  logic             link_write_q, link_write_d;
  logic [XLEN-1:0]  branch_pc_q, branch_pc_d;
  logic [4:0]       link_reg_q, link_reg_d;
  logic [XLEN-1:0]  link_addr_q, link_addr_d;
  logic [XLEN-1:0]  pend_target_q, pend_target_d;
  logic             pend_link_q, pend_link_d;
  logic [4:0]       pend_link_reg_q, pend_link_reg_d;
  logic [XLEN-1:0]  pend_link_addr_q, pend_link_addr_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic             issue;
  logic [XLEN-1:0]  iss_target;
  logic             iss_link;
  logic [4:0]       iss_link_reg;
  logic [XLEN-1:0]  iss_link_addr;

  branch_decide #(
    .XLEN        (XLEN),
    .ENABLE_JALR (ENABLE_JALR)
  ) u_decide (
    .valid_i          (Valid_ID),
    .instr_i          (Instruction),
    .pc_hi_i          (PC_Plus_4[XLEN-1:28]),
    .pc_plus_branch_i (PC_Plus_Branch),
    .rs_i             (Reg_Data1),
    .rt_i             (Reg_Data2),
    .take_o           (dec_take),
    .target_o         (dec_target),
    .is_cond_o        (dec_cond),
    .is_link_o        (dec_link),
    .link_reg_o       (dec_link_reg)
  );

  assign dec_link_addr = PC_Plus_4 + XLEN'(4);

  // Redirect source: latched info when releasing a stalled decision, live decode otherwise.
  always_comb begin
    if (state_q == ST_PENDING) begin
      iss_target    = pend_target_q;
      iss_link      = pend_link_q;
      iss_link_reg  = pend_link_reg_q;
      iss_link_addr = pend_link_addr_q;
    end else begin
      iss_target    = dec_target;
      iss_link      = dec_link;
      iss_link_reg  = dec_link_reg;
      iss_link_addr = dec_link_addr;
    end
  end

  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    pcsel_d          = 1'b0;
    link_write_d     = 1'b0;
    branch_pc_d      = branch_pc_q;
    link_reg_d       = link_reg_q;
    link_addr_d      = link_addr_q;
    pend_target_d    = pend_target_q;
    pend_link_d      = pend_link_q;
    pend_link_reg_d  = pend_link_reg_q;
    pend_link_addr_d = pend_link_addr_q;
    branch_cnt_d     = branch_cnt_q;
    taken_cnt_d      = taken_cnt_q;
    issue            = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dec_cond) begin
          branch_cnt_d = (branch_cnt_q == '1) ? branch_cnt_q : branch_cnt_q + 1'b1;
          if (dec_take) begin
            taken_cnt_d = (taken_cnt_q == '1) ? taken_cnt_q : taken_cnt_q + 1'b1;
          end
        end
        if (dec_take) begin
          if (Stall_PC) begin
            pend_target_d    = dec_target;
            pend_link_d      = dec_link;
            pend_link_reg_d  = dec_link_reg;
            pend_link_addr_d = dec_link_addr;
            state_d          = ST_PENDING;
          end else begin
            issue = 1'b1;
          end
        end
      end
      ST_PENDING: begin
        if (!Stall_PC) begin
          issue = 1'b1;
        end
      end
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt_q - 1'b1;
        if (flush_cnt_q == FW'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (issue) begin
      pcsel_d      = 1'b1;
      link_write_d = iss_link;
      branch_pc_d  = iss_target;
      if (iss_link) begin
        link_reg_d  = iss_link_reg;
        link_addr_d = iss_link_addr;
      end
      state_d     = ST_FLUSH;
      flush_cnt_d = FLUSH_INIT;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q          <= ST_IDLE;
      flush_cnt_q      <= '0;
      pcsel_q          <= 1'b0;
      link_write_q     <= 1'b0;
      branch_pc_q      <= '0;
      link_reg_q       <= '0;
      link_addr_q      <= '0;
      pend_target_q    <= '0;
      pend_link_q      <= 1'b0;
      pend_link_reg_q  <= '0;
      pend_link_addr_q <= '0;
      branch_cnt_q     <= '0;
      taken_cnt_q      <= '0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      pcsel_q          <= pcsel_d;
      link_write_q     <= link_write_d;
      branch_pc_q      <= branch_pc_d;
      link_reg_q       <= link_reg_d;
      link_addr_q      <= link_addr_d;
      pend_target_q    <= pend_target_d;
      pend_link_q      <= pend_link_d;
      pend_link_reg_q  <= pend_link_reg_d;
      pend_link_addr_q <= pend_link_addr_d;
      branch_cnt_q     <= branch_cnt_d;
      taken_cnt_q      <= taken_cnt_d;
    end
  end

  assign PCSel        = pcsel_q;
  assign Link_Write   = link_write_q;
  assign BranchPC     = branch_pc_q;
  assign Link_Reg     = link_reg_q;
  assign Link_Addr    = link_addr_q;
  assign Flush_IF     = (state_q == ST_FLUSH);
  assign Branch_Count = branch_cnt_q;
  assign Taken_Count  = taken_cnt_q;

endmodule
